ddr_axi_rw_arbiter: RTL and testbench



---
 rtl/ddr_axi_pkg.sv | 20 ++
 rtl/ddr_axi_watchdog.sv | 40 ++++
 rtl/ddr_axi_rw_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ddr_axi_rw_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the DDR AXI port-0 read/write arbiter.
package ddr_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_DATA
   } arb_state_e;

   localparam logic [2:0] ASIZE_128    = 3'b100;
   localparam logic [1:0] BURST_INCR   = 2'b01;
   localparam logic [1:0] ALOCK_NORMAL = 2'b00;
   localparam logic       ATYPE_WR     = 1'b1;
   localparam logic       ATYPE_RD     = 1'b0;
   localparam logic [7:0] DEF_WR_ID    = 8'h00;
   localparam logic [7:0] DEF_RD_ID    = 8'h01;

endpackage

// File: rtl/ddr_axi_watchdog.sv
// No-progress watchdog: counts while a burst is in flight, expires after
// TIMEOUT_CYCLES quiet cycles and latches a sticky error.
module ddr_axi_watchdog
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic expire_o,
   output logic err_o
);

   localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;
   logic        err_q;

   // A clearing handshake in the expiry cycle suppresses the expiry.
   assign expire_o = !clr_i && (cnt_q == LAST_CNT);
   assign err_o    = err_q;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (clr_i || expire_o)
         cnt_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (expire_o)
            err_q <= 1'b1;
      end
   end

endmodule

// File: rtl/ddr_axi_rw_arbiter.sv
// Shares DDR AXI port 0 between the camera write path and the LCD read path;
// one burst outstanding, tracked to completion on W/B or R.
module ddr_axi_rw_arbiter
   import ddr_axi_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 4096,
   parameter logic [7:0] WR_ID          = DEF_WR_ID,
   parameter logic [7:0] RD_ID          = DEF_RD_ID
) (
   input  logic        axi_clk,
   input  logic        axi_reset,
   input  logic        wr_req,
   input  logic        rd_req,
   input  logic [31:0] wr_addr,
   input  logic [31:0] rd_addr,
   input  logic [7:0]  wr_len,
   input  logic [7:0]  rd_len,
   input  logic        rd_urgent,
   output logic        wr_grant,
   output logic        rd_grant,
   output logic        wr_done,
   output logic        rd_done,
   output logic        wr_active,
   output logic        rd_active,
   output logic [7:0]  axi_aid,
   output logic [31:0] axi_aaddr,
   output logic [7:0]  axi_alen,
   output logic [2:0]  axi_asize,
   output logic [1:0]  axi_aburst,
   output logic [1:0]  axi_alock,
   output logic        axi_avalid,
   input  logic        axi_aready,
   output logic        axi_atype,
   input  logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic        axi_wlast,
   input  logic        axi_bvalid,
   input  logic        axi_bready,
   input  logic        axi_rvalid,
   input  logic        axi_rready,
   input  logic        axi_rlast,
   output logic        timeout_err
);

   arb_state_e  state_q;
   logic        avalid_q, atype_q, last_wr_q, wlast_seen_q;
   logic        wr_grant_q, rd_grant_q, wr_done_q, rd_done_q;
   logic        wr_active_q, rd_active_q;
   logic [7:0]  aid_q, alen_q;
   logic [31:0] aaddr_q;

   logic a_hs, w_hs, wlast_hs, b_hs, r_hs, rlast_hs, any_hs;
   logic wd_clr, wd_expire;
   logic pick_any, pick_rd;

   assign a_hs     = avalid_q & axi_aready;
   assign w_hs     = axi_wvalid & axi_wready;
   assign wlast_hs = w_hs & axi_wlast;
   assign b_hs     = axi_bvalid & axi_bready;
   assign r_hs     = axi_rvalid & axi_rready;
   assign rlast_hs = r_hs & axi_rlast;
   assign any_hs   = a_hs | w_hs | b_hs | r_hs;
   assign wd_clr   = (state_q == ST_IDLE) | any_hs;

   // Urgent reads pre-empt; otherwise a contested cycle goes to the side not served last.
   assign pick_any = wr_req | rd_req;
   always_comb begin
      pick_rd = rd_req;
      if (rd_req && rd_urgent)
         pick_rd = 1'b1;
      else if (rd_req && wr_req)
         pick_rd = last_wr_q;
   end

   ddr_axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .clk_i    (axi_clk),
      .rst_i    (axi_reset),
      .clr_i    (wd_clr),
      .expire_o (wd_expire),
      .err_o    (timeout_err)
   );

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q      <= ST_IDLE;
         avalid_q     <= 1'b0;
         atype_q      <= ATYPE_RD;
         aid_q        <= '0;
         aaddr_q      <= '0;
         alen_q       <= '0;
         last_wr_q    <= 1'b1;
         wlast_seen_q <= 1'b0;
         wr_grant_q   <= 1'b0;
         rd_grant_q   <= 1'b0;
         wr_done_q    <= 1'b0;
         rd_done_q    <= 1'b0;
         wr_active_q  <= 1'b0;
         rd_active_q  <= 1'b0;
      end else begin
         wr_grant_q <= 1'b0;
         rd_grant_q <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_done_q  <= 1'b0;
         // Write data may lead the address, so wlast is remembered from ADDR onward.
         if (wlast_hs && (state_q == ST_ADDR || state_q == ST_WR_DATA))
            wlast_seen_q <= 1'b1;
         if (wd_expire) begin
            state_q      <= ST_IDLE;
            avalid_q     <= 1'b0;
            wr_active_q  <= 1'b0;
            rd_active_q  <= 1'b0;
            wlast_seen_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: if (pick_any) begin
                  state_q     <= ST_ADDR;
                  avalid_q    <= 1'b1;
                  atype_q     <= pick_rd ? ATYPE_RD : ATYPE_WR;
                  aid_q       <= pick_rd ? RD_ID : WR_ID;
                  aaddr_q     <= pick_rd ? rd_addr : wr_addr;
                  alen_q      <= pick_rd ? rd_len : wr_len;
                  last_wr_q   <= !pick_rd;
                  wr_active_q <= !pick_rd;
                  rd_active_q <= pick_rd;
               end
               ST_ADDR: if (a_hs) begin
                  avalid_q <= 1'b0;
                  if (atype_q == ATYPE_WR) begin
                     wr_grant_q <= 1'b1;
                     state_q    <= (wlast_seen_q || wlast_hs) ? ST_WR_RESP : ST_WR_DATA;
                  end else begin
                     rd_grant_q <= 1'b1;
                     state_q    <= ST_RD_DATA;
                  end
               end
               ST_WR_DATA: if (wlast_hs)
                  state_q <= ST_WR_RESP;
               ST_WR_RESP: if (b_hs) begin
                  state_q      <= ST_IDLE;
                  wr_done_q    <= 1'b1;
                  wr_active_q  <= 1'b0;
                  wlast_seen_q <= 1'b0;
               end
               ST_RD_DATA: if (rlast_hs) begin
                  state_q      <= ST_IDLE;
                  rd_done_q    <= 1'b1;
                  rd_active_q  <= 1'b0;
                  wlast_seen_q <= 1'b0;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign wr_grant   = wr_grant_q;
   assign rd_grant   = rd_grant_q;
   assign wr_done    = wr_done_q;
   assign rd_done    = rd_done_q;
   assign wr_active  = wr_active_q;
   assign rd_active  = rd_active_q;
   assign axi_aid    = aid_q;
   assign axi_aaddr  = aaddr_q;
   assign axi_alen   = alen_q;
   assign axi_avalid = avalid_q;
   assign axi_atype  = atype_q;
   assign axi_asize  = ASIZE_128;
   assign axi_aburst = BURST_INCR;
   assign axi_alock  = ALOCK_NORMAL;

endmodule

// File: tb/tb_ddr_axi_rw_arbiter.sv
// Bench for ddr_axi_rw_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ddr_axi_rw_arbiter;

   localparam int TO = 64;
   localparam logic [7:0] G_R = 8'h52;
   localparam logic [7:0] G_W = 8'h57;

   logic        axi_clk, axi_reset;
   logic        wr_req, rd_req, rd_urgent;
   logic [31:0] wr_addr, rd_addr;
   logic [7:0]  wr_len, rd_len;
   logic        wr_grant, rd_grant, wr_done, rd_done, wr_active, rd_active;
   logic [7:0]  axi_aid, axi_alen;
   logic [31:0] axi_aaddr;
   logic [2:0]  axi_asize;
   logic [1:0]  axi_aburst, axi_alock;
   logic        axi_avalid, axi_aready, axi_atype;
   logic        axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
   logic        axi_rvalid, axi_rready, axi_rlast, timeout_err;

   ddr_axi_rw_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset),
      .wr_req(wr_req), .rd_req(rd_req), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .wr_len(wr_len), .rd_len(rd_len), .rd_urgent(rd_urgent),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_done(wr_done), .rd_done(rd_done),
      .wr_active(wr_active), .rd_active(rd_active),
      .axi_aid(axi_aid), .axi_aaddr(axi_aaddr), .axi_alen(axi_alen),
      .axi_asize(axi_asize), .axi_aburst(axi_aburst), .axi_alock(axi_alock),
      .axi_avalid(axi_avalid), .axi_aready(axi_aready), .axi_atype(axi_atype),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
      .timeout_err(timeout_err)
   );

   int n_chk = 0, n_err = 0;
   int cnt_wg = 0, cnt_rg = 0, cnt_wd = 0, cnt_rd = 0;
   logic [7:0] gq[$];

   // Reference model: one burst record plus a quiet-cycle counter.
   logic        m_busy = 0, m_wr = 0, m_acc = 0, m_dend = 0, m_last_wr = 1, m_err = 0;
   logic        m_avalid = 0, m_atype = 0, m_wg = 0, m_rg = 0, m_wdn = 0, m_rdn = 0;
   logic [7:0]  m_aid = 0, m_alen = 0;
   logic [31:0] m_aaddr = 0;
   int          m_wd = 0;
   logic        mh_a, mh_w, mh_wl, mh_b, mh_r, mh_rl, mh_any, m_fin, m_take_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (axi_reset) begin
         m_busy = 0; m_wr = 0; m_acc = 0; m_dend = 0; m_last_wr = 1; m_err = 0;
         m_avalid = 0; m_atype = 0; m_aid = 0; m_alen = 0; m_aaddr = 0; m_wd = 0;
         m_wg = 0; m_rg = 0; m_wdn = 0; m_rdn = 0;
      end else begin
         mh_a   = m_avalid && axi_aready;
         mh_w   = axi_wvalid && axi_wready;
         mh_wl  = mh_w && axi_wlast;
         mh_b   = axi_bvalid && axi_bready;
         mh_r   = axi_rvalid && axi_rready;
         mh_rl  = mh_r && axi_rlast;
         mh_any = mh_a || mh_w || mh_b || mh_r;
         m_wg = 0; m_rg = 0; m_wdn = 0; m_rdn = 0;
         if (!m_busy) begin
            m_wd = 0;
            if (wr_req || rd_req) begin
               if (rd_req && rd_urgent) m_take_rd = 1;
               else if (rd_req && wr_req) m_take_rd = m_last_wr;
               else m_take_rd = rd_req;
               m_busy = 1; m_acc = 0; m_dend = 0; m_avalid = 1;
               m_wr = !m_take_rd; m_last_wr = !m_take_rd; m_atype = !m_take_rd;
               m_aid   = m_take_rd ? 8'h01 : 8'h00;
               m_aaddr = m_take_rd ? rd_addr : wr_addr;
               m_alen  = m_take_rd ? rd_len : wr_len;
            end
         end else begin
            m_fin = m_acc && (m_wr ? (m_dend && mh_b) : mh_rl);
            if (!mh_any && m_wd == TO - 1) begin
               m_busy = 0; m_avalid = 0; m_err = 1; m_wd = 0;
            end else begin
               m_wd = mh_any ? 0 : m_wd + 1;
               if (m_fin) begin
                  m_busy = 0;
                  if (m_wr) m_wdn = 1; else m_rdn = 1;
               end else begin
                  if (mh_a) begin
                     m_acc = 1; m_avalid = 0;
                     if (m_wr) m_wg = 1; else m_rg = 1;
                  end
                  if (m_wr && mh_wl) m_dend = 1;
               end
            end
         end
      end
   endtask

   initial begin
      axi_clk = 0;
      forever #5 axi_clk = ~axi_clk;
   end

   initial forever begin
      @(posedge axi_clk or posedge axi_reset);
      model_step();
   end

   initial forever begin
      @(negedge axi_clk);
      if (wr_grant) begin cnt_wg++; gq.push_back(G_W); end
      if (rd_grant) begin cnt_rg++; gq.push_back(G_R); end
      if (wr_done) cnt_wd++;
      if (rd_done) cnt_rd++;
      chk("grant",  32'({wr_grant, rd_grant}),   32'({m_wg, m_rg}));
      chk("done",   32'({wr_done, rd_done}),     32'({m_wdn, m_rdn}));
      chk("active", 32'({wr_active, rd_active}), 32'({m_busy && m_wr, m_busy && !m_wr}));
      chk("avalid", 32'(axi_avalid), 32'(m_avalid));
      chk("atype",  32'(axi_atype),  32'(m_atype));
      chk("aid",    32'(axi_aid),    32'(m_aid));
      chk("aaddr",  axi_aaddr,       m_aaddr);
      chk("alen",   32'(axi_alen),   32'(m_alen));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      chk("const",  32'({axi_asize, axi_aburst, axi_alock}), 32'h44);
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic slave_all(input logic on);
      axi_aready = on; axi_wvalid = on; axi_wready = on; axi_wlast = on;
      axi_bvalid = on; axi_bready = on; axi_rvalid = on; axi_rready = on; axi_rlast = on;
   endtask

   task automatic zero_counts();
      cnt_wg = 0; cnt_rg = 0; cnt_wd = 0; cnt_rd = 0;
      gq.delete();
   endtask

   task automatic drain();
      wr_req = 0; rd_req = 0; rd_urgent = 0;
      slave_all(1); repeat (6) tick();
      slave_all(0); repeat (2) tick();
   endtask

   task automatic wait_avalid(input string nm);
      int k = 0;
      while (!axi_avalid && k < 20) begin tick(); k++; end
      chk(nm, 32'(axi_avalid), 1);
   endtask

   task automatic wait_grants(input int n);
      int k = 0;
      while (gq.size() < n && k < 100) begin tick(); k++; end
   endtask

   task automatic w_beat(input logic last);
      axi_wvalid = 1; axi_wready = 1; axi_wlast = last;
      tick();
      axi_wvalid = 0; axi_wready = 0; axi_wlast = 0;
   endtask

   int k, quiet_left;

   initial begin
      axi_reset = 1;
      wr_req = 0; rd_req = 0; rd_urgent = 0;
      wr_addr = 0; rd_addr = 0; wr_len = 0; rd_len = 0;
      slave_all(0);
      repeat (3) tick();
      chk("rst_avalid", 32'(axi_avalid), 0);
      chk("rst_active", 32'({wr_active, rd_active}), 0);
      chk("rst_aaddr", axi_aaddr, 0);
      axi_reset = 0;
      tick();

      // Round-robin with both sides requesting continuously
      zero_counts();
      wr_addr = 32'h100; wr_len = 1; rd_addr = 32'h200; rd_len = 2;
      slave_all(1); wr_req = 1; rd_req = 1;
      wait_grants(8);
      wr_req = 0; rd_req = 0;
      chk("rr_count", gq.size(), 8);
      for (int i = 0; i < 8; i++)
         chk("rr_order", 32'(i < gq.size() ? gq[i] : 8'h0), 32'(i % 2 == 0 ? G_R : G_W));
      drain();

      // Urgent reads pre-empt the round robin
      zero_counts();
      slave_all(1); rd_urgent = 1; wr_req = 1; rd_req = 1;
      wait_grants(4);
      rd_urgent = 0;
      wait_grants(6);
      wr_req = 0; rd_req = 0;
      for (int i = 0; i < 4; i++)
         chk("urg_reads", 32'(i < gq.size() ? gq[i] : 8'h0), 32'(G_R));
      chk("urg_after_w", 32'(gq.size() > 4 ? gq[4] : 8'h0), 32'(G_W));
      chk("urg_after_r", 32'(gq.size() > 5 ? gq[5] : 8'h0), 32'(G_R));
      drain();

      // Single write, aready two cycles late, 16 beats then B
      zero_counts();
      wr_addr = 32'h0000_1000; wr_len = 15; wr_req = 1;
      wait_avalid("wr1_avalid");
      chk("wr1_atype", 32'(axi_atype), 1);
      chk("wr1_aid", 32'(axi_aid), 0);
      chk("wr1_alen", 32'(axi_alen), 15);
      chk("wr1_aaddr", axi_aaddr, 32'h0000_1000);
      chk("wr1_model_aaddr", m_aaddr, 32'h0000_1000);
      chk("wr1_active", 32'(wr_active), 1);
      tick(); tick();
      axi_aready = 1; tick(); axi_aready = 0; wr_req = 0;
      chk("wr1_grant", 32'(wr_grant), 1);
      for (int i = 0; i < 16; i++) w_beat(i == 15);
      chk("wr1_active_mid", 32'(wr_active), 1);
      axi_bvalid = 1; axi_bready = 1; tick(); axi_bvalid = 0; axi_bready = 0;
      chk("wr1_done", 32'(wr_done), 1);
      chk("wr1_active_end", 32'(wr_active), 0);
      tick();
      chk("wr1_ngrant", cnt_wg, 1);
      chk("wr1_ndone", cnt_wd, 1);
      drain();

      // Write data completes before the address is accepted
      zero_counts();
      wr_addr = 32'h0000_2000; wr_len = 3; wr_req = 1;
      wait_avalid("wr2_avalid");
      for (int i = 0; i < 4; i++) w_beat(i == 3);
      chk("wr2_nogrant", cnt_wg, 0);
      axi_aready = 1; tick(); axi_aready = 0; wr_req = 0;
      chk("wr2_grant", 32'(wr_grant), 1);
      tick(); tick();
      chk("wr2_waiting", 32'({wr_done, wr_active}), 32'b01);
      axi_bvalid = 1; axi_bready = 1; tick(); axi_bvalid = 0; axi_bready = 0;
      chk("wr2_done", 32'(wr_done), 1);
      drain();

      // Read whose rlast never arrives
      zero_counts();
      rd_addr = 32'h0000_3000; rd_len = 7; rd_req = 1;
      wait_avalid("to_avalid");
      axi_aready = 1; tick(); axi_aready = 0; rd_req = 0;
      chk("to_grant", 32'(rd_grant), 1);
      axi_rvalid = 1; axi_rready = 1; axi_rlast = 0;
      repeat (3) tick();
      axi_rvalid = 0; axi_rready = 0;
      k = 0;
      while (!timeout_err && k < 200) begin tick(); k++; end
      chk("to_cycles", k, TO);
      chk("to_model_err", 32'(m_err), 1);
      chk("to_rd_active", 32'(rd_active), 0);
      chk("to_no_done", cnt_rd, 0);
      wr_addr = 32'h0000_4000; wr_len = 0; wr_req = 1;
      wait_avalid("to_wr_avalid");
      axi_aready = 1; tick(); axi_aready = 0; wr_req = 0;
      w_beat(1);
      axi_bvalid = 1; axi_bready = 1; tick(); axi_bvalid = 0; axi_bready = 0;
      tick();
      chk("to_wr_done", cnt_wd, 1);
      chk("to_sticky", 32'(timeout_err), 1);
      drain();

      // Reset asserted in the middle of a write burst
      zero_counts();
      wr_addr = 32'h0000_5000; wr_len = 7; wr_req = 1;
      wait_avalid("rst_wr_avalid");
      axi_aready = 1; tick(); axi_aready = 0; wr_req = 0;
      w_beat(0); w_beat(0);
      chk("rst_pre_active", 32'(wr_active), 1);
      #2 axi_reset = 1;
      #1;
      chk("rst_now_outs", 32'({axi_avalid, wr_active, rd_active, wr_grant, wr_done, axi_atype, timeout_err}), 0);
      chk("rst_now_aaddr", axi_aaddr, 0);
      chk("rst_now_aid_alen", 32'({axi_aid, axi_alen}), 0);
      tick(); tick();
      axi_reset = 0;
      zero_counts();
      slave_all(1); wr_req = 1; rd_req = 1;
      wait_grants(1);
      chk("rst_first_rd", 32'(gq.size() > 0 ? gq[0] : 8'h0), 32'(G_R));
      drain();

      // Random traffic with occasional silent stretches that trip the watchdog
      quiet_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (quiet_left > 0) begin
            quiet_left--;
            slave_all(0);
         end else begin
            if ($urandom_range(399) == 0) quiet_left = 70;
            axi_aready = $urandom_range(2) != 0;
            axi_wvalid = $urandom_range(1) != 0; axi_wready = $urandom_range(1) != 0;
            axi_wlast  = $urandom_range(3) == 0;
            axi_bvalid = $urandom_range(3) == 0; axi_bready = $urandom_range(1) != 0;
            axi_rvalid = $urandom_range(1) != 0; axi_rready = $urandom_range(1) != 0;
            axi_rlast  = $urandom_range(3) == 0;
         end
         if (wr_req && wr_grant) wr_req = 0;
         else if (!wr_req && $urandom_range(3) == 0) begin
            wr_req = 1; wr_addr = $urandom; wr_len = 8'($urandom);
         end
         if (rd_req && rd_grant) rd_req = 0;
         else if (!rd_req && $urandom_range(3) == 0) begin
            rd_req = 1; rd_addr = $urandom; rd_len = 8'($urandom);
         end
         rd_urgent = $urandom_range(4) == 0;
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
